ball_horizontal: RTL and testbench
==================================

BALL_HORIZONTAL -- requirements
Module: ball_horizontal

Interface
REQ-001 Parameter X_MIN, default 9'd82: leftmost legal ball_x; crossing it is a left miss.
REQ-002 Parameter X_MAX, default 9'd446: rightmost legal ball_x; crossing it is a right miss.
REQ-003 Parameter X_CENTER, default 9'd264: serve position.
REQ-004 Parameter SERVE_FRAMES, default 6'd32: frames ball stays hidden before serve.
REQ-005 clk7_159  input  1  pixel-domain clock; the block has one clock; reset is synchronous and active-high.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ce_pix  input  1  pixel clock enable; all state updates occur only on clk7_159 edges with ce_pix=1.
REQ-008 hcount  input  9  current horizontal pixel count, 0..453.
REQ-009 v_end  input  1  one-ce_pix pulse at end of frame; motion update strobe.
REQ-010 hit_l / hit_r  input  1 each  left/right paddle coincidence with ball.
REQ-011 attract  input  1  attract mode: edges bounce, no misses.
REQ-012 hvid  output  1  ball horizontal video window.
REQ-013 ball_x  output  9  current ball left-edge position.
REQ-014 dir  output  1  1 = moving right, 0 = moving left.
REQ-015 speed  output  2  pixels per frame, 1..3.
REQ-016 miss_l / miss_r  output  1 each  one-clock pulse on left/right miss.
REQ-017 serving  output  1  high while in SERVE_WAIT.

Function
REQ-018 States: SERVE_WAIT, PLAY; two-state FSM, encoding free.
REQ-019 SERVE_WAIT: each v_end increments 6-bit frame timer; on v_end with timer==SERVE_FRAMES-1 -> ball_x=X_CENTER, hits=0, timer=0, state PLAY.
REQ-020 PLAY: hit_l=1 and hit_r=0 -> dir=1; hit_r=1 and hit_l=0 -> dir=0; both high -> ignored.
REQ-021 Hit counter (4 bits) increments only when a hit actually changes dir; saturates at 15; hits while already moving away ignored.
REQ-022 speed = 1 for hits 0..3, 2 for hits 4..11, 3 for hits 12..15; combinational from hit counter.
REQ-023 PLAY, on v_end: next = dir ? ball_x+speed : ball_x-speed, computed 10-bit, no wrap.
REQ-024 Hit and v_end in same ce cycle: new dir and new speed used for that cycle's move.
REQ-025 dir=0 and next < X_MIN: attract=1 -> ball_x=X_MIN, dir=1, hits unchanged; attract=0 -> miss_l pulse, state SERVE_WAIT, timer=0, ball_x unchanged.
REQ-026 dir=1 and next > X_MAX: attract=1 -> ball_x=X_MAX, dir=0; attract=0 -> miss_r pulse, state SERVE_WAIT, timer=0.
REQ-027 Next exactly equal to X_MIN or X_MAX is legal; no miss, no bounce.
REQ-028 Serve dir: after miss_l dir=0, after miss_r dir=1 (served toward missing player); set at the miss.
REQ-029 miss_l/miss_r high exactly one clk7_159 cycle; never both.
REQ-030 hvid registered: on ce_pix, hvid <= (state==PLAY) and 0 <= hcount-ball_x <= 3; one clk latency; low in SERVE_WAIT.
REQ-031 hit_l/hit_r ignored in SERVE_WAIT; attract change mid-play takes effect at next edge check.
REQ-032 serving = (state==SERVE_WAIT), combinational.

Reset
REQ-033 reset wins over ce_pix and all inputs; takes effect on the next clk7_159 edge.
REQ-034 Reset values: state SERVE_WAIT, timer 0, ball_x X_CENTER, dir 1, hits 0 (speed 1), hvid 0, miss_l 0, miss_r 0, serving 1.
REQ-035 Reset asserted mid-PLAY or mid-pulse clears everything per REQ-034 in one cycle; no miss pulse emitted.

Verification
REQ-036 Reset, then 32 v_end pulses -> serving falls, ball_x=264, dir=1, speed=1; hvid high for hcount 264..267 only, one clk late.
REQ-037 PLAY dir=1, 4 alternating direction-changing hits -> speed=2; 12 total -> speed=3; 20 -> stays 3; repeated hit_r while dir=0 -> hits unchanged.
REQ-038 attract=0, ball_x=83, dir=0, speed=2, v_end -> miss_l one cycle, serving=1, hvid low; after 32 frames ball_x=264, dir=0.
REQ-039 attract=1, ball_x=445, dir=1, speed=3, v_end -> ball_x=446, dir=0, no miss pulse.
REQ-040 hit_l and hit_r together -> dir unchanged; hit_l coincident with v_end at ball_x=100 dir=0 speed=1 -> ball_x=101, dir=1.
REQ-041 reset asserted during PLAY at ball_x=300 -> next cycle all REQ-034 values, miss outputs stay 0.

Source files
------------

// File: rtl/ball_horizontal.sv
// Ball horizontal motion: serve timer, paddle bounces, edge miss/bounce, and hvid window.
// Motion updates once per frame on v_end; hvid has one ce_pix of latency; there is no backpressure.
module ball_horizontal #(
    parameter logic [8:0] X_MIN        = 9'd82,
    parameter logic [8:0] X_MAX        = 9'd446,
    parameter logic [8:0] X_CENTER     = 9'd264,
    parameter logic [5:0] SERVE_FRAMES = 6'd32
) (
    input  logic       clk7_159,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [8:0] hcount,
    input  logic       v_end,
    input  logic       hit_l,
    input  logic       hit_r,
    input  logic       attract,
    output logic       hvid,
    output logic [8:0] ball_x,
    output logic       dir,
    output logic [1:0] speed,
    output logic       miss_l,
    output logic       miss_r,
    output logic       serving
);

    typedef enum logic {SERVE_WAIT, PLAY} state_t;

    state_t     state_q, state_d;
    logic [5:0] timer_q, timer_d;
    logic [8:0] ball_x_q, ball_x_d;
    logic       dir_q, dir_d;
    logic [3:0] hits_q, hits_d;
    logic       hvid_q, hvid_d;
    logic       miss_l_q, miss_l_d;
    logic       miss_r_q, miss_r_d;

    logic [3:0] hits_hit;
    logic       dir_hit;
    logic [1:0] step;
    logic [9:0] next_x;
    logic [9:0] left_limit;
    logic [9:0] win_off;

    function automatic logic [1:0] speed_of(input logic [3:0] h);
        if (h <= 4'd3)       return 2'd1;
        else if (h <= 4'd11) return 2'd2;
        else                 return 2'd3;
    endfunction

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ball_x_d = ball_x_q;
        dir_d    = dir_q;
        hits_d   = hits_q;
        hvid_d   = hvid_q;
        miss_l_d = 1'b0;
        miss_r_d = 1'b0;

        // Paddle hit resolved first so a same-cycle move uses the new dir and speed.
        hits_hit = hits_q;
        dir_hit  = dir_q;
        if (hit_l && !hit_r && !dir_q) begin
            dir_hit  = 1'b1;
            hits_hit = (hits_q == 4'd15) ? hits_q : hits_q + 4'd1;
        end else if (hit_r && !hit_l && dir_q) begin
            dir_hit  = 1'b0;
            hits_hit = (hits_q == 4'd15) ? hits_q : hits_q + 4'd1;
        end

        step       = speed_of(hits_hit);
        next_x     = dir_hit ? ({1'b0, ball_x_q} + {8'd0, step})
                             : ({1'b0, ball_x_q} - {8'd0, step});
        left_limit = {1'b0, X_MIN} + {8'd0, step};
        win_off    = {1'b0, hcount} - {1'b0, ball_x_q};

        if (ce_pix) begin
            hvid_d = (state_q == PLAY) && (win_off <= 10'd3);
            case (state_q)
                SERVE_WAIT: begin
                    if (v_end) begin
                        if (timer_q == SERVE_FRAMES - 6'd1) begin
                            state_d  = PLAY;
                            timer_d  = 6'd0;
                            ball_x_d = X_CENTER;
                            hits_d   = 4'd0;
                        end else begin
                            timer_d = timer_q + 6'd1;
                        end
                    end
                end
                PLAY: begin
                    dir_d  = dir_hit;
                    hits_d = hits_hit;
                    if (v_end) begin
                        if (dir_hit) begin
                            if (next_x > {1'b0, X_MAX}) begin
                                if (attract) begin
                                    ball_x_d = X_MAX;
                                    dir_d    = 1'b0;
                                end else begin
                                    miss_r_d = 1'b1;
                                    state_d  = SERVE_WAIT;
                                    timer_d  = 6'd0;
                                    dir_d    = 1'b1;
                                end
                            end else begin
                                ball_x_d = next_x[8:0];
                            end
                        end else begin
                            // Compare before subtracting so a small ball_x cannot wrap.
                            if ({1'b0, ball_x_q} < left_limit) begin
                                if (attract) begin
                                    ball_x_d = X_MIN;
                                    dir_d    = 1'b1;
                                end else begin
                                    miss_l_d = 1'b1;
                                    state_d  = SERVE_WAIT;
                                    timer_d  = 6'd0;
                                    dir_d    = 1'b0;
                                end
                            end else begin
                                ball_x_d = next_x[8:0];
                            end
                        end
                    end
                end
                default: state_d = SERVE_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk7_159) begin
        if (reset) begin
            state_q  <= SERVE_WAIT;
            timer_q  <= 6'd0;
            ball_x_q <= X_CENTER;
            dir_q    <= 1'b1;
            hits_q   <= 4'd0;
            hvid_q   <= 1'b0;
            miss_l_q <= 1'b0;
            miss_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ball_x_q <= ball_x_d;
            dir_q    <= dir_d;
            hits_q   <= hits_d;
            hvid_q   <= hvid_d;
            miss_l_q <= miss_l_d;
            miss_r_q <= miss_r_d;
        end
    end

    assign hvid    = hvid_q;
    assign ball_x  = ball_x_q;
    assign dir     = dir_q;
    assign speed   = speed_of(hits_q);
    assign miss_l  = miss_l_q;
    assign miss_r  = miss_r_q;
    assign serving = (state_q == SERVE_WAIT);

endmodule

// File: tb/tb_ball_horizontal.sv
// Bench for ball_horizontal: frame-level integer model checked every cycle plus literal checkpoints.
module tb_ball_horizontal;

    logic       clk7_159 = 1'b0;
    logic       reset    = 1'b1;
    logic       ce_pix   = 1'b0;
    logic [8:0] hcount   = 9'd0;
    logic       v_end    = 1'b0;
    logic       hit_l    = 1'b0;
    logic       hit_r    = 1'b0;
    logic       attract  = 1'b0;
    logic       hvid;
    logic [8:0] ball_x;
    logic       dir;
    logic [1:0] speed;
    logic       miss_l;
    logic       miss_r;
    logic       serving;

    ball_horizontal dut (
        .clk7_159(clk7_159),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .hcount  (hcount),
        .v_end   (v_end),
        .hit_l   (hit_l),
        .hit_r   (hit_r),
        .attract (attract),
        .hvid    (hvid),
        .ball_x  (ball_x),
        .dir     (dir),
        .speed   (speed),
        .miss_l  (miss_l),
        .miss_r  (miss_r),
        .serving (serving)
    );

    always #5 clk7_159 = ~clk7_159;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int spd(input int h);
        if (h < 4)  return 1;
        if (h < 12) return 2;
        return 3;
    endfunction

    // Game model in plain integers: position, direction, hit count, serve countdown.
    int m_serving, m_timer, m_x, m_dir, m_hits, m_hvid, m_ml, m_mr, nx;

    always @(posedge clk7_159) begin
        if (reset) begin
            m_serving = 1; m_timer = 0; m_x = 264; m_dir = 1; m_hits = 0;
            m_hvid = 0; m_ml = 0; m_mr = 0;
        end else begin
            m_ml = 0; m_mr = 0;
            if (ce_pix) begin
                m_hvid = (!m_serving && int'(hcount) >= m_x && int'(hcount) <= m_x + 3) ? 1 : 0;
                if (m_serving) begin
                    if (v_end) begin
                        if (m_timer == 31) begin
                            m_serving = 0; m_timer = 0; m_x = 264; m_hits = 0;
                        end else begin
                            m_timer++;
                        end
                    end
                end else begin
                    if (hit_l && !hit_r && m_dir == 0) begin
                        m_dir = 1; if (m_hits < 15) m_hits++;
                    end else if (hit_r && !hit_l && m_dir == 1) begin
                        m_dir = 0; if (m_hits < 15) m_hits++;
                    end
                    if (v_end) begin
                        nx = m_dir ? m_x + spd(m_hits) : m_x - spd(m_hits);
                        if (nx < 82) begin
                            if (attract) begin m_x = 82; m_dir = 1; end
                            else begin m_ml = 1; m_serving = 1; m_timer = 0; m_dir = 0; end
                        end else if (nx > 446) begin
                            if (attract) begin m_x = 446; m_dir = 0; end
                            else begin m_mr = 1; m_serving = 1; m_timer = 0; m_dir = 1; end
                        end else begin
                            m_x = nx;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk7_159) begin
        if (chk_en) begin
            chk("hvid",    int'(hvid),    m_hvid);
            chk("ball_x",  int'(ball_x),  m_x);
            chk("dir",     int'(dir),     m_dir);
            chk("speed",   int'(speed),   spd(m_hits));
            chk("miss_l",  int'(miss_l),  m_ml);
            chk("miss_r",  int'(miss_r),  m_mr);
            chk("serving", int'(serving), m_serving);
        end
    end

    // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
    task automatic step(input logic ce, input logic ve, input logic hl, input logic hr,
                        input logic att, input logic [8:0] hc);
        ce_pix = ce; v_end = ve; hit_l = hl; hit_r = hr; attract = att; hcount = hc;
        @(negedge clk7_159);
    endtask

    task automatic frames(input int n, input logic att);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, att, 9'd0);
            step(1'b1, 1'b0, 1'b0, 1'b0, att, 9'd0);
        end
    endtask

    task automatic hit(input logic l, input logic r);
        step(1'b1, 1'b0, l, r, 1'b0, 9'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk7_159);
        @(negedge clk7_159);
        chk_en = 1;
        chk("rst serving", int'(serving), 1);
        chk("rst ball_x",  int'(ball_x),  264);
        chk("rst dir",     int'(dir),     1);
        chk("rst speed",   int'(speed),   1);
        chk("rst hvid",    int'(hvid),    0);
        reset = 1'b0;

        // Serve countdown: 31 frames still hidden, v_end without ce ignored, 32nd serves.
        frames(31, 1'b0);
        chk("serve 31", int'(serving), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
        chk("serve no ce", int'(serving), 1);
        frames(1, 1'b0);
        chk("serve 32",   int'(serving), 0);
        chk("serve x",    int'(ball_x),  264);
        chk("serve dir",  int'(dir),     1);

        for (int h = 260; h <= 270; h++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'(h));
            chk("hvid win", int'(hvid), (h >= 264 && h <= 267) ? 1 : 0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
        chk("ce hold x", int'(ball_x), 264);

        // Hit counting: only direction-changing hits count.
        hit(1'b0, 1'b1); hit(1'b1, 1'b0); hit(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) hit(1'b0, 1'b1);
        chk("rep hit speed", int'(speed), 1);
        hit(1'b1, 1'b0);
        chk("4 hits speed", int'(speed), 2);
        hit(1'b1, 1'b1);
        chk("both dir", int'(dir), 1);
        for (int i = 0; i < 4; i++) begin hit(1'b0, 1'b1); hit(1'b1, 1'b0); end
        chk("12 hits speed", int'(speed), 3);
        for (int i = 0; i < 4; i++) begin hit(1'b0, 1'b1); hit(1'b1, 1'b0); end
        chk("20 hits speed", int'(speed), 3);

        // Left miss at 83, speed 2.
        do_reset();
        frames(32, 1'b0);
        hit(1'b0, 1'b1);
        frames(1, 1'b0);
        hit(1'b1, 1'b0); hit(1'b0, 1'b1); hit(1'b1, 1'b0); hit(1'b0, 1'b1);
        frames(90, 1'b0);
        chk("pre miss x", int'(ball_x), 83);
        chk("pre miss spd", int'(speed), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
        chk("miss_l pulse", int'(miss_l),  1);
        chk("miss serving", int'(serving), 1);
        chk("miss x held",  int'(ball_x),  83);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd83);
        chk("miss_l end", int'(miss_l), 0);
        chk("miss hvid",  int'(hvid),   0);
        frames(32, 1'b0);
        chk("reserve x",   int'(ball_x), 264);
        chk("reserve dir", int'(dir),    0);

        // Attract bounce at right edge from 445, speed 3; then left bounce.
        hit(1'b1, 1'b0);
        frames(1, 1'b0);
        for (int i = 0; i < 6; i++) begin hit(1'b0, 1'b1); hit(1'b1, 1'b0); end
        frames(60, 1'b0);
        chk("pre bounce x", int'(ball_x), 445);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0);
        chk("bounce r x",    int'(ball_x), 446);
        chk("bounce r dir",  int'(dir),    0);
        chk("bounce r miss", int'(miss_r), 0);
        frames(121, 1'b1);
        chk("pre bounce l", int'(ball_x), 83);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0);
        chk("bounce l x",   int'(ball_x), 82);
        chk("bounce l dir", int'(dir),    1);
        chk("bounce l spd", int'(speed),  3);

        // Hit coincident with v_end, exact X_MIN legal, attract drop then miss.
        do_reset();
        frames(32, 1'b0);
        hit(1'b0, 1'b1);
        frames(164, 1'b0);
        chk("at 100", int'(ball_x), 100);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        chk("hit+vend x",   int'(ball_x), 101);
        chk("hit+vend dir", int'(dir),    1);
        hit(1'b1, 1'b1);
        hit(1'b0, 1'b1);
        frames(19, 1'b1);
        chk("edge eq x",   int'(ball_x),  82);
        chk("edge eq srv", int'(serving), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
        chk("att off miss", int'(miss_l), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);

        // Reset mid-play at 300.
        frames(32, 1'b0);
        hit(1'b1, 1'b0);
        frames(36, 1'b0);
        chk("at 300", int'(ball_x), 300);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'd300);
        reset = 1'b0;
        chk("mid rst serving", int'(serving), 1);
        chk("mid rst x",       int'(ball_x),  264);
        chk("mid rst dir",     int'(dir),     1);
        chk("mid rst miss",    int'(miss_l) + int'(miss_r), 0);

        // Reset on the cycle a miss would fire.
        frames(32, 1'b0);
        hit(1'b0, 1'b1);
        frames(182, 1'b0);
        chk("at 82", int'(ball_x), 82);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
        reset = 1'b0;
        chk("rst miss supp", int'(miss_l), 0);
        chk("rst miss x",    int'(ball_x), 264);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
